// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory controller.
//   dmem_state_t : access FSM states
//   CNT_W        : wait-state counter width (WAIT_STATES 0..15)
//   dmem_nb()    : number of byte lanes for a given data width
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int CNT_W = 4;

  function automatic int dmem_nb(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: Memory-stage <-> data-memory handshake bundle.
//   master (core) drives : req, we, byteEnable, a, wd
//   slave (dmem) drives  : rd, stall, done, fault
interface dmem_if
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);
  localparam int NB = dmem_nb(DATA_WIDTH);

  logic                  req;
  logic                  we;
  logic [NB-1:0]         byteEnable;
  logic [31:0]           a;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] rd;
  logic                  stall;
  logic                  done;
  logic                  fault;

  modport master (
    output req, we, byteEnable, a, wd,
    input  rd, stall, done, fault
  );

  modport slave (
    input  req, we, byteEnable, a, wd,
    output rd, stall, done, fault
  );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA_WIDTH word storage.
//   clk   : write clock
//   we    : word write strobe, qualified per lane by be
//   be    : per-byte-lane write enable
//   addr  : word index shared by read and write
//   wdata : lane-aligned write data
//   rdata : asynchronous read of mem[addr]
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 1024,
  localparam int NB         = dmem_nb(DATA_WIDTH),
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [NB-1:0]         be,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller with configurable wait states.
//   clk : clock, clr : synchronous active-high reset
//   bus : dmem_if slave (req/we/byteEnable/a/wd in; rd/stall/done/fault out)
// WAIT_STATES=0 gives single-cycle timing (combinational read, no stall).
// WAIT_STATES>=1 stalls the core for exactly WAIT_STATES cycles; done and a
// registered read word appear in the following cycle.
// Build option DMEM_BOUNDS_CHECK_EN: addresses >= DEPTH*NB bytes are flagged
// with fault, writes to them are dropped and reads return 0. Without it the
// upper address bits are ignored (accesses alias modulo DEPTH words).
//
// state | meaning
// IDLE  | no access; req raises stall and starts an access
// BUSY  | waiting; cnt counts down, last BUSY cycle is cnt=1
// DONE  | completion cycle: done=1, rd valid, write commits at its end
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input logic   clk,
  input logic   clr,
  dmem_if.slave bus
);

  localparam int NB = dmem_nb(DATA_WIDTH);
  localparam int LB = (NB > 1) ? $clog2(NB) : 0;
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]         word_idx;
  logic                  oob;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] rdata_masked;
  logic                  addr_unused;

  assign word_idx    = bus.a[AW+LB-1:LB];
  assign addr_unused = ^bus.a;

`ifdef DMEM_BOUNDS_CHECK_EN
  // 33 bits so DEPTH*NB = 2^32 does not wrap to zero
  localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'(NB);
  assign oob = ({1'b0, bus.a} >= LIMIT);
`else
  assign oob = 1'b0;
`endif

  assign rdata_masked = oob ? '0 : mem_rdata;

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (bus.byteEnable),
    .addr  (word_idx),
    .wdata (bus.wd),
    .rdata (mem_rdata)
  );

  if (WAIT_STATES == 0) begin : g_comb
    assign mem_we    = bus.req & bus.we & ~clr & ~oob;
    assign bus.rd    = rdata_masked;
    assign bus.stall = 1'b0;
    assign bus.done  = bus.req;
    assign bus.fault = bus.req & oob;
  end else begin : g_fsm
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES - 1);

    dmem_state_t           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;

    always_ff @(posedge clk) begin
      if (clr) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        rd_q    <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rd_q    <= rd_d;
      end
    end

    // Read word is captured on every edge that enters DONE, including the
    // direct IDLE->DONE path when only one wait state is configured.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            cnt_d = CNT_INIT;
            if (WAIT_STATES == 1) begin
              state_d = DONE;
              rd_d    = rdata_masked;
            end else begin
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
            rd_d    = rdata_masked;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_comb begin
      bus.stall = ((state_q == IDLE) & bus.req) | (state_q == BUSY);
      bus.done  = (state_q == DONE);
      bus.fault = (state_q == DONE) & oob;
      mem_we    = (state_q == DONE) & bus.we & ~clr & ~oob;
    end

    assign bus.rd = rd_q;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  dmem_if #(.DATA_WIDTH(32)) if2 ();
  dmem_if #(.DATA_WIDTH(32)) if0 ();

  dmem_ctrl #(.DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(2)) u_dut2 (
    .clk (clk), .clr (clr), .bus (if2.slave)
  );

  dmem_ctrl #(.DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .clk (clk), .clr (clr), .bus (if0.slave)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] a;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_fault;
  } vec_t;

  vec_t vecs2 [15];
  vec_t vecs0 [6];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One access on the 2-wait-state instance; entered and left at posedge+1.
  task automatic access2(input vec_t v, input int idx);
    bit seen;
    seen = 1'b0;
    if2.req = 1'b1; if2.we = v.we; if2.byteEnable = v.be; if2.a = v.a; if2.wd = v.wd;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      if (if2.done) begin
        seen = 1'b1;
        check($sformatf("v%0d_latency", idx), 32'(cyc), 32'd2);
        check($sformatf("v%0d_stall_done", idx), {31'b0, if2.stall}, 32'd0);
        check($sformatf("v%0d_fault", idx), {31'b0, if2.fault}, {31'b0, v.exp_fault});
        if (v.chk_rd) check($sformatf("v%0d_rd", idx), if2.rd, v.exp_rd);
      end else begin
        check($sformatf("v%0d_stall_c%0d", idx, cyc), {31'b0, if2.stall}, 32'd1);
      end
      @(posedge clk); #1;
    end
    if (!seen) check($sformatf("v%0d_done_timeout", idx), 32'd0, 32'd1);
    if2.req = 1'b0; if2.we = 1'b0;
  endtask

  // One single-cycle access on the 0-wait-state instance.
  task automatic access0(input vec_t v, input int idx);
    if0.req = 1'b1; if0.we = v.we; if0.byteEnable = v.be; if0.a = v.a; if0.wd = v.wd;
    @(negedge clk);
    check($sformatf("w0_v%0d_done", idx), {31'b0, if0.done}, 32'd1);
    check($sformatf("w0_v%0d_stall", idx), {31'b0, if0.stall}, 32'd0);
    check($sformatf("w0_v%0d_fault", idx), {31'b0, if0.fault}, {31'b0, v.exp_fault});
    if (v.chk_rd) check($sformatf("w0_v%0d_rd", idx), if0.rd, v.exp_rd);
    @(posedge clk); #1;
    if0.req = 1'b0; if0.we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] exp_stall;
    logic [5:0] exp_done;

    //           we    be     a          wd            chk   exp_rd                      fault
    vecs0[0] = '{1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,                      1'b0};
    vecs0[1] = '{1'b0, 4'h0, 32'h10,   32'h0,        1'b1, 32'hDEADBEEF,               1'b0};
    vecs0[2] = '{1'b1, 4'hF, 32'h0,    32'h0A0B0C0D, 1'b0, 32'h0,                      1'b0};
    vecs0[3] = '{1'b1, 4'hF, 32'h1000, 32'hCAFEF00D, 1'b0, 32'h0,                      BC};
    vecs0[4] = '{1'b0, 4'h0, 32'h0,    32'h0,        1'b1, BC ? 32'h0A0B0C0D : 32'hCAFEF00D, 1'b0};
    vecs0[5] = '{1'b0, 4'h0, 32'h1000, 32'h0,        1'b1, BC ? 32'h0 : 32'hCAFEF00D,  BC};

    vecs2[0]  = '{1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,                      1'b0};
    vecs2[1]  = '{1'b0, 4'h0, 32'h10,   32'h0,        1'b1, 32'hDEADBEEF,               1'b0};
    vecs2[2]  = '{1'b1, 4'h2, 32'h10,   32'h0000AA00, 1'b0, 32'h0,                      1'b0};
    vecs2[3]  = '{1'b0, 4'h0, 32'h10,   32'h0,        1'b1, 32'hDEADAAEF,               1'b0};
    vecs2[4]  = '{1'b1, 4'hF, 32'h14,   32'h11223344, 1'b0, 32'h0,                      1'b0};
    vecs2[5]  = '{1'b1, 4'h0, 32'h14,   32'hFFFFFFFF, 1'b0, 32'h0,                      1'b0};
    vecs2[6]  = '{1'b0, 4'h0, 32'h14,   32'h0,        1'b1, 32'h11223344,               1'b0};
    vecs2[7]  = '{1'b1, 4'h8, 32'h15,   32'hAB000000, 1'b0, 32'h0,                      1'b0};
    vecs2[8]  = '{1'b0, 4'h0, 32'h17,   32'h0,        1'b1, 32'hAB223344,               1'b0};
    vecs2[9]  = '{1'b1, 4'hF, 32'h0,    32'h01020304, 1'b0, 32'h0,                      1'b0};
    vecs2[10] = '{1'b1, 4'hF, 32'h1000, 32'hCAFEF00D, 1'b0, 32'h0,                      BC};
    vecs2[11] = '{1'b0, 4'h0, 32'h0,    32'h0,        1'b1, BC ? 32'h01020304 : 32'hCAFEF00D, 1'b0};
    vecs2[12] = '{1'b0, 4'h0, 32'h1000, 32'h0,        1'b1, BC ? 32'h0 : 32'hCAFEF00D,  BC};
    vecs2[13] = '{1'b1, 4'hF, 32'h20,   32'h00000000, 1'b0, 32'h0,                      1'b0};
    vecs2[14] = '{1'b0, 4'h0, 32'h10,   32'h0,        1'b1, 32'hDEADAAEF,               1'b0};

    clr = 1'b1;
    if2.req = 1'b0; if2.we = 1'b0; if2.byteEnable = '0; if2.a = '0; if2.wd = '0;
    if0.req = 1'b0; if0.we = 1'b0; if0.byteEnable = '0; if0.a = '0; if0.wd = '0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;

    @(negedge clk);
    check("rst_stall2", {31'b0, if2.stall}, 32'd0);
    check("rst_done2",  {31'b0, if2.done},  32'd0);
    check("rst_fault2", {31'b0, if2.fault}, 32'd0);
    check("rst_rd2",    if2.rd,             32'd0);
    check("rst_stall0", {31'b0, if0.stall}, 32'd0);
    check("rst_done0",  {31'b0, if0.done},  32'd0);
    check("rst_fault0", {31'b0, if0.fault}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) access0(vecs0[i], i);
    @(negedge clk);
    check("w0_idle_done", {31'b0, if0.done}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) access2(vecs2[i], i);

    // clr during BUSY drops the pending write to 0x20
    if2.req = 1'b1; if2.we = 1'b1; if2.byteEnable = 4'hF; if2.a = 32'h20; if2.wd = 32'h12345678;
    @(negedge clk);
    check("clr_stall_c0", {31'b0, if2.stall}, 32'd1);
    @(posedge clk); #1;
    clr = 1'b1;
    @(negedge clk);
    check("clr_stall_c1", {31'b0, if2.stall}, 32'd1);
    @(posedge clk); #1;
    clr = 1'b0; if2.req = 1'b0; if2.we = 1'b0;
    for (int c = 2; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("clr_stall_c%0d", c), {31'b0, if2.stall}, 32'd0);
      check($sformatf("clr_done_c%0d", c),  {31'b0, if2.done},  32'd0);
      check($sformatf("clr_rd_c%0d", c),    if2.rd,             32'd0);
      @(posedge clk); #1;
    end
    access2('{1'b0, 4'h0, 32'h20, 32'h0, 1'b1, 32'h0, 1'b0}, 100);

    // back-to-back reads with req held high throughout
    exp_stall = 6'b011011;
    exp_done  = 6'b100100;
    if2.req = 1'b1; if2.we = 1'b0; if2.byteEnable = '0; if2.a = 32'h10;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) if2.a = 32'h14;
      @(negedge clk);
      check($sformatf("b2b_stall_c%0d", c), {31'b0, if2.stall}, {31'b0, exp_stall[c]});
      check($sformatf("b2b_done_c%0d", c),  {31'b0, if2.done},  {31'b0, exp_done[c]});
      if (c == 2) check("b2b_rd_c2", if2.rd, 32'hDEADAAEF);
      if (c == 5) check("b2b_rd_c5", if2.rd, 32'hAB223344);
      @(posedge clk); #1;
    end
    if2.req = 1'b0;
    @(negedge clk);
    check("b2b_idle_stall", {31'b0, if2.stall}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
